// File: rtl/evm_multi.sv
// evm_multi: multi-voter EVM FSM with per-candidate tallies and a voted-ID bitmap.
// Optional VOTE-state time limit is compiled in by defining EVM_TIMEOUT_EN.
module evm_multi #(
   parameter int ID_W     = 3,
   parameter int NUM_CAND = 4,
   parameter int OPT_W    = 2,
   parameter int CNT_W    = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [ID_W-1:0]  id,
   input  logic             option_valid,
   input  logic [OPT_W-1:0] option,
   output logic             varified,
   output logic             not_varified,
   output logic             vote_lock,
   output logic             bad_option,
   output logic             busy,
   input  logic [OPT_W-1:0] tally_sel,
   output logic [CNT_W-1:0] tally_count,
   output logic [CNT_W-1:0] total_votes
);
   localparam int               NUM_ID     = 1 << ID_W;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [OPT_W:0]   NUM_CAND_W = (OPT_W + 1)'(NUM_CAND);

   typedef enum logic [1:0] {S_IDLE, S_VERIFY, S_VOTE, S_LOCK} state_t;

   state_t                         state_q, state_d;
   logic [ID_W-1:0]                cur_id_q, cur_id_d;
   logic [NUM_ID-1:0]              voted_q;
   logic [CNT_W-1:0]               total_q;
   logic [NUM_CAND-1:0][CNT_W-1:0] tally_vec;

   logic varified_q, varified_d;
   logic not_varified_q, not_varified_d;
   logic vote_lock_q, vote_lock_d;
   logic bad_option_q, bad_option_d;
   logic busy_q, busy_d;

   logic id_ok, opt_legal, commit, bad, tmo_hit;

   assign id_ok     = (cur_id_q != '0) && !voted_q[cur_id_q];
   assign opt_legal = ({1'b0, option} < NUM_CAND_W);
   assign commit    = (state_q == S_VOTE) && option_valid && opt_legal;
   assign bad       = (state_q == S_VOTE) && option_valid && !opt_legal;

`ifdef EVM_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;

   // Counts idle VOTE cycles; the last allowed idle cycle raises tmo_hit.
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

   always_comb begin
      tmo_d = tmo_q + TMO_W'(1);
      if (state_q != S_VOTE || bad || tmo_hit) tmo_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   // No time limit: constant-false for any legal TIMEOUT, so VOTE waits forever.
   assign tmo_hit = (TIMEOUT < 0);
`endif

   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      case (state_q)
         S_IDLE: begin
            if (id_valid) begin
               cur_id_d = id;
               state_d  = S_VERIFY;
            end
         end
         S_VERIFY: state_d = id_ok ? S_VOTE : S_IDLE;
         S_VOTE: begin
            if (commit)              state_d = S_LOCK;
            else if (!bad && tmo_hit) state_d = S_IDLE;
         end
         S_LOCK:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      varified_d     = (state_d == S_VOTE);
      busy_d         = (state_d != S_IDLE);
      vote_lock_d    = (state_d == S_LOCK);
      bad_option_d   = bad;
      not_varified_d = ((state_q == S_VERIFY) && !id_ok) ||
                       ((state_q == S_VOTE) && !commit && !bad && tmo_hit);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         cur_id_q       <= '0;
         voted_q        <= '0;
         total_q        <= '0;
         varified_q     <= 1'b0;
         not_varified_q <= 1'b0;
         vote_lock_q    <= 1'b0;
         bad_option_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cur_id_q       <= cur_id_d;
         varified_q     <= varified_d;
         not_varified_q <= not_varified_d;
         vote_lock_q    <= vote_lock_d;
         bad_option_q   <= bad_option_d;
         busy_q         <= busy_d;
         if (commit) begin
            voted_q[cur_id_q] <= 1'b1;
            if (total_q != CNT_MAX) total_q <= total_q + CNT_W'(1);
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_tally
         logic [CNT_W-1:0] cnt_q;
         always_ff @(posedge clk) begin
            if (!reset)
               cnt_q <= '0;
            else if (commit && option == OPT_W'(gi) && cnt_q != CNT_MAX)
               cnt_q <= cnt_q + CNT_W'(1);
         end
         assign tally_vec[gi] = cnt_q;
      end
   endgenerate

   always_comb begin
      tally_count = '0;
      for (int i = 0; i < NUM_CAND; i++)
         if (tally_sel == OPT_W'(i)) tally_count = tally_vec[i];
   end

   assign varified     = varified_q;
   assign not_varified = not_varified_q;
   assign vote_lock    = vote_lock_q;
   assign bad_option   = bad_option_q;
   assign busy         = busy_q;
   assign total_votes  = total_q;
endmodule

// File: tb/tb_evm_multi.sv
// Scoreboard bench for evm_multi: driver predicts outcome events from a ballot-level
// model; a negedge monitor pops and checks them as the DUT pulses its outputs.
module tb_evm_multi;
   localparam int ID_W     = 3;
   localparam int NUM_CAND = 3;
   localparam int OPT_W    = 2;
   localparam int CNT_W    = 2;
   localparam int TIMEOUT  = 4;
   localparam int NUM_ID   = 1 << ID_W;
   localparam int CMAX     = (1 << CNT_W) - 1;
   localparam int K_VER = 0, K_REJ = 1, K_BAD = 2, K_LOCK = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             id_valid = 1'b0;
   logic [ID_W-1:0]  id = '0;
   logic             option_valid = 1'b0;
   logic [OPT_W-1:0] option = '0;
   logic [OPT_W-1:0] tally_sel = '0;
   logic             varified, not_varified, vote_lock, bad_option, busy;
   logic [CNT_W-1:0] tally_count, total_votes;

   evm_multi #(.ID_W(ID_W), .NUM_CAND(NUM_CAND), .OPT_W(OPT_W), .CNT_W(CNT_W),
               .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id(id),
      .option_valid(option_valid), .option(option), .varified(varified),
      .not_varified(not_varified), .vote_lock(vote_lock), .bad_option(bad_option),
      .busy(busy), .tally_sel(tally_sel), .tally_count(tally_count),
      .total_votes(total_votes));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   function automatic void chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Ballot-level reference model
   bit m_voted[NUM_ID];
   int m_tally[NUM_CAND];
   int m_total;

   typedef struct {int kind; int at; int total;} exp_t;
   exp_t sb[$];
   bit   mon_en = 1'b0;
   logic ver_prev = 1'b0;

   function automatic void push(int kind, int at);
      exp_t e;
      e.kind = kind; e.at = at; e.total = m_total;
      sb.push_back(e);
   endfunction

   function automatic void model_clear();
      foreach (m_voted[i]) m_voted[i] = 1'b0;
      foreach (m_tally[i]) m_tally[i] = 0;
      m_total = 0;
   endfunction

   task automatic check_event(int kind);
      exp_t e;
      if (sb.size() == 0) begin
         chk("unexpected_event", kind, -1);
         return;
      end
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      case (e.kind)
         K_VER: chk("busy_verified", int'(busy), 1);
         K_REJ: begin
            chk("busy_reject", int'(busy), 0);
            chk("varified_reject", int'(varified), 0);
         end
         K_BAD: begin
            chk("varified_bad", int'(varified), 1);
            chk("busy_bad", int'(busy), 1);
         end
         K_LOCK: begin
            chk("total_votes_lock", int'(total_votes), e.total);
            chk("varified_lock", int'(varified), 0);
            chk("busy_lock", int'(busy), 1);
         end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         while (sb.size() > 0 && sb[0].at < cyc) begin
            chk("missed_event", -1, sb[0].kind);
            void'(sb.pop_front());
         end
         if (varified && !ver_prev) check_event(K_VER);
         if (not_varified)          check_event(K_REJ);
         if (bad_option)            check_event(K_BAD);
         if (vote_lock)             check_event(K_LOCK);
      end
      ver_prev = varified;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_tallies();
      for (int s = 0; s < (1 << OPT_W); s++) begin
         tally_sel = OPT_W'(s);
         #1;
         chk("tally_count", int'(tally_count), (s < NUM_CAND) ? m_tally[s] : 0);
      end
   endtask

   task automatic check_idle_outputs();
      chk("rst_varified", int'(varified), 0);
      chk("rst_not_varified", int'(not_varified), 0);
      chk("rst_vote_lock", int'(vote_lock), 0);
      chk("rst_bad_option", int'(bad_option), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_total_votes", int'(total_votes), 0);
      read_tallies();
   endtask

   task automatic do_reset(int ncyc);
      reset = 1'b0; id_valid = 1'b0; option_valid = 1'b0;
      repeat (ncyc) step();
      model_clear();
      check_idle_outputs();
      reset = 1'b1;
   endtask

   task automatic ballot(int vid, int nbad, int w, int opt, bit mid_rst, output string res);
      int elapsed = 0;
      bit accept = (vid != 0) && !m_voted[vid];
      id = vid[ID_W-1:0]; id_valid = 1'b1;
      option_valid = 1'($urandom_range(0, 1)); option = OPT_W'($urandom);
      push(accept ? K_VER : K_REJ, cyc + 2);
      step();
      id_valid = 1'($urandom_range(0, 1)); id = ID_W'($urandom);
      option_valid = 1'($urandom_range(0, 1)); option = OPT_W'($urandom);
      step();
      id_valid = 1'b0; option_valid = 1'b0;
      if (!accept) begin res = "rejected"; return; end
      for (int k = 0; k <= nbad; k++) begin
         for (int j = 0; j < w; j++) begin
            id_valid = 1'($urandom_range(0, 1)); id = ID_W'($urandom);
            option_valid = 1'b0;
`ifdef EVM_TIMEOUT_EN
            if (elapsed == TIMEOUT - 1) begin
               push(K_REJ, cyc + 1);
               step();
               id_valid = 1'b0;
               res = "timeout";
               return;
            end
`endif
            elapsed++;
            step();
         end
         id_valid = 1'($urandom_range(0, 1)); id = ID_W'($urandom);
         if (mid_rst && k == nbad) begin
            do_reset(1);
            res = "reset mid-ballot";
            return;
         end
         if (k < nbad) begin
            option = OPT_W'($urandom_range(NUM_CAND, (1 << OPT_W) - 1));
            option_valid = 1'b1;
            push(K_BAD, cyc + 1);
            elapsed = 0;
            step();
         end else begin
            option = OPT_W'(opt); option_valid = 1'b1;
            if (m_tally[opt] < CMAX) m_tally[opt]++;
            if (m_total < CMAX) m_total++;
            m_voted[vid] = 1'b1;
            push(K_LOCK, cyc + 1);
            step();
            id_valid = 1'($urandom_range(0, 1)); option_valid = 1'($urandom_range(0, 1));
            tally_sel = OPT_W'(opt);
            #1;
            chk("tally_after_lock", int'(tally_count), m_tally[opt]);
            step();
            id_valid = 1'b0; option_valid = 1'b0;
            res = "voted";
         end
      end
   endtask

   int n_txn = 0;
   task automatic run(int vid, int nbad, int w, int opt, bit mid_rst);
      string r;
      ballot(vid, nbad, w, opt, mid_rst, r);
      n_txn++;
      $display("txn %0d: id=%0d bad=%0d wait=%0d opt=%0d -> %s", n_txn, vid, nbad, w, opt, r);
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) step();
      model_clear();
      check_idle_outputs();
      reset = 1'b1;
      mon_en = 1'b1;

      run(1, 0, 0, 2, 1'b0);
      run(1, 0, 0, 0, 1'b0);
      run(0, 0, 0, 1, 1'b0);
      run(3, 1, 0, 0, 1'b0);
      run(2, 0, 1, 1, 1'b0);
      run(4, 0, 0, 1, 1'b0);
      run(5, 0, 2, 1, 1'b0);
      run(6, 0, 0, 1, 1'b0);
      read_tallies();
      chk("total_saturated", int'(total_votes), m_total);

      do_reset(2);
      run(5, 0, 1, 0, 1'b1);
      run(5, 0, 0, 2, 1'b0);
`ifdef EVM_TIMEOUT_EN
      run(6, 0, TIMEOUT, 1, 1'b0);
      run(6, 0, TIMEOUT - 1, 1, 1'b0);
      run(7, 1, TIMEOUT - 1, 0, 1'b0);
`endif

      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 9) == 0) do_reset(1);
         run($urandom_range(0, NUM_ID - 1), $urandom_range(0, 2), $urandom_range(0, 5),
             $urandom_range(0, NUM_CAND - 1), $urandom_range(0, 19) == 0);
      end

      repeat (3) step();
      chk("scoreboard_drained", sb.size(), 0);
      read_tallies();
      chk("total_votes_final", int'(total_votes), m_total);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/evm_multi.md
Name: evm_multi

Overview:
- Parametrised successor to the single-ballot EVM FSM.
- Supports 2^ID_W voter IDs and NUM_CAND candidates, with per-candidate tally counters.
- Blocks repeat voting through a voted-ID bitmap and rejects out-of-range options.
- Sits between the voter keypad/ID-reader front end and the results display/readout logic.

Parameters:
- ID_W, 3, voter ID width; 2^ID_W voter slots; ID 0 is reserved and always invalid.
- NUM_CAND, 4, number of candidates; legal options are 0..NUM_CAND-1; range 2..2^OPT_W.
- OPT_W, 2, option bus width.
- CNT_W, 8, width of each tally counter and of total_votes.
- TIMEOUT, 16, VOTE-state cycle limit; used only with EVM_TIMEOUT_EN.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-low reset.
- id_valid, input, 1, single-cycle strobe; id is sampled only in IDLE.
- id, input, ID_W, voter ID.
- option_valid, input, 1, single-cycle strobe; option is sampled only in VOTE.
- option, input, OPT_W, candidate index.
- varified, output, 1, high throughout VOTE (voter accepted).
- not_varified, output, 1, one-cycle pulse when a voter is rejected.
- vote_lock, output, 1, one-cycle pulse when a ballot is committed.
- bad_option, output, 1, one-cycle pulse when an out-of-range option is seen in VOTE.
- busy, output, 1, high in any state other than IDLE.
- tally_sel, input, OPT_W, candidate selected for readout.
- tally_count, output, CNT_W, combinational read of tally[tally_sel]; reads 0 if tally_sel >= NUM_CAND.
- total_votes, output, CNT_W, count of committed ballots.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - All tallies, total_votes and the voted bitmap cleared.
  - varified, not_varified, vote_lock, bad_option and busy all 0.
  - Reset wins over every other event, including mid-ballot; a partial ballot is discarded.
- All outputs except tally_count are registered.
- State machine (one-hot or binary; encoding is free):
  - IDLE: on id_valid, latch id into cur_id and go to VERIFY next cycle. Otherwise stay.
  - VERIFY (exactly 1 cycle):
    - If cur_id!=0 and voted[cur_id]==0: go to VOTE and set varified=1.
    - Else: go to IDLE and pulse not_varified for the 1 cycle following VERIFY.
  - VOTE: varified held at 1. On option_valid:
    - If option<NUM_CAND: tally[option] += 1, total_votes += 1, voted[cur_id] set, varified cleared, go to LOCK.
    - Else: pulse bad_option for 1 cycle, stay in VOTE with no state change.
  - LOCK (exactly 1 cycle): vote_lock=1, then IDLE.
- Latency: id_valid edge → varified high 2 cycles later; option_valid edge → vote_lock high 1 cycle later.
- Saturation:
  - A tally at 2^CNT_W-1 holds its value; total_votes saturates independently.
  - voted[cur_id] is still set and vote_lock still pulses.
- Ignored inputs:
  - id_valid outside IDLE.
  - option_valid outside VOTE.
- Simultaneous id_valid and option_valid: only the strobe that applies to the current state acts.
- A rejected voter does not alter any state except the not_varified pulse.
- The bitmap persists until reset; there is no other clear path.

Optional Feature:
- Macro: EVM_TIMEOUT_EN.
- Defined:
  - A counter runs in VOTE, cleared on entry to VOTE and on each bad_option.
  - If TIMEOUT cycles elapse with no legal option, go to IDLE, clear varified, and pulse not_varified for 1 cycle.
  - No tally change and no bitmap change on timeout; the voter may retry.
  - If a legal option arrives on the same cycle the count reaches TIMEOUT, the vote wins.
- Undefined: VOTE waits indefinitely; no counter logic is synthesised.

Test Plan:
- New voter: reset low for 2 cycles, id=1 with id_valid, then option=2 with option_valid → varified=1 two cycles after the id strobe; vote_lock pulses for 1 cycle; tally[2]=1; total_votes=1.
- Double vote: repeat id=1 after the first ballot → not_varified pulses for 1 cycle; varified stays 0; tallies unchanged.
- Reserved ID and bad option:
  - id=0 → not_varified pulses.
  - id=3, then option=3 with NUM_CAND=3 → bad_option pulses and the FSM stays in VOTE; then option=0 → tally[0]=1.
- Saturation: CNT_W=2, IDs 1..4 all vote option 1 → tally[1] stays at 3; total_votes=3; every ballot gets a vote_lock pulse.
- Reset mid-ballot: id=5 verified, reset asserted in VOTE → all outputs 0, tallies 0; id=5 can then vote again successfully.
- Timeout (EVM_TIMEOUT_EN, TIMEOUT=4): id=6 verified, no option for 4 cycles → not_varified pulse, return to IDLE, tallies unchanged; id=6 then votes successfully.
